// File: rtl/stack_engine.sv
// ---------------------------------------------------------------------------
// stack_engine
//   Multi-cycle stack sequencer for PUSH / POP / CALL / RET. Takes the current
//   SP from the register bank, performs one data-memory access over a req/ack
//   handshake, then issues single-cycle write-back strobes (SP, register, PC).
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start, op                 request strobe (sampled in IDLE) and opcode
//                             (00 PUSH, 01 POP, 10 CALL, 11 RET)
//   push_data, ret_addr,      operands latched when a request is accepted
//   call_target, sp_in
//   mem_req/we/addr/wdata     memory request, held until mem_ack
//   mem_rdata, mem_ack        memory read data and one-cycle completion
//   sp_wdata, sp_write        SP write-back
//   reg_wdata, reg_write      popped value (POP only)
//   pc_target, pc_load        new PC (CALL / RET only)
//   busy, done, err           status; err pulses together with done
// ---------------------------------------------------------------------------
module stack_engine #(
  parameter logic [31:0] STACK_BASE  = 32'd16,
  parameter logic [31:0] STACK_LIMIT = 32'd0,
  parameter logic [31:0] SP_STEP     = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] push_data,
  input  logic [31:0] ret_addr,
  input  logic [31:0] call_target,
  input  logic [31:0] sp_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] sp_wdata,
  output logic        sp_write,
  output logic [31:0] reg_wdata,
  output logic        reg_write,
  output logic [31:0] pc_target,
  output logic        pc_load,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_COMMIT, S_ERR} state_t;

  localparam logic [1:0] OP_POP = 2'b01;
  localparam logic [1:0] OP_RET = 2'b11;

  state_t      r_state;
  state_t      w_state_next;

  logic [1:0]  r_op;
  logic [31:0] r_push_data;
  logic [31:0] r_ret_addr;
  logic [31:0] r_call_target;
  logic [31:0] r_sp;

  logic [31:0] r_sp_wdata;
  logic        r_sp_write;
  logic [31:0] r_reg_wdata;
  logic        r_reg_write;
  logic [31:0] r_pc_target;
  logic        r_pc_load;
  logic        r_done;
  logic        r_err;

  // op[0] == 0 marks the writing ops (PUSH, CALL); op[1] == 1 marks the PC ops.
  logic        w_start_is_write;
  logic        w_bound_err;
  logic        w_is_write;

  assign w_start_is_write = ~op[0];
  assign w_bound_err      = w_start_is_write ? (sp_in == STACK_LIMIT)
                                             : (sp_in == STACK_BASE);
  assign w_is_write       = ~r_op[0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = w_bound_err ? S_ERR : S_MEM;
      S_MEM:    if (mem_ack) w_state_next = S_COMMIT;
      S_COMMIT: w_state_next = S_IDLE;
      S_ERR:    w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Memory-side outputs decode directly from the state register so mem_req
  // falls in the first cycle after reset or ack, and stays stable while waiting.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    busy      = (r_state != S_IDLE);
    if (r_state == S_MEM) begin
      mem_req = 1'b1;
      mem_we  = w_is_write;
      if (w_is_write) begin
        mem_addr  = r_sp - SP_STEP;
        mem_wdata = r_op[1] ? r_ret_addr : r_push_data;
      end else begin
        mem_addr  = r_sp;
      end
    end
  end

  // Operand capture on accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op          <= 2'b00;
      r_push_data   <= 32'd0;
      r_ret_addr    <= 32'd0;
      r_call_target <= 32'd0;
      r_sp          <= 32'd0;
    end else if (r_state == S_IDLE && start) begin
      r_op          <= op;
      r_push_data   <= push_data;
      r_ret_addr    <= ret_addr;
      r_call_target <= call_target;
      r_sp          <= sp_in;
    end
  end

  // Commit strobes are registered off the next state, so they are high exactly
  // during COMMIT / ERR. Read data is captured here on the ack edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp_wdata  <= 32'd0;
      r_sp_write  <= 1'b0;
      r_reg_wdata <= 32'd0;
      r_reg_write <= 1'b0;
      r_pc_target <= 32'd0;
      r_pc_load   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sp_write  <= (w_state_next == S_COMMIT);
      r_reg_write <= (w_state_next == S_COMMIT) && (r_op == OP_POP);
      r_pc_load   <= (w_state_next == S_COMMIT) && r_op[1];
      r_done      <= (w_state_next == S_COMMIT) || (w_state_next == S_ERR);
      r_err       <= (w_state_next == S_ERR);
      if (w_state_next == S_COMMIT) begin
        r_sp_wdata <= w_is_write ? (r_sp - SP_STEP) : (r_sp + SP_STEP);
        if (r_op == OP_POP) r_reg_wdata <= mem_rdata;
        if (r_op[1])        r_pc_target <= (r_op == OP_RET) ? mem_rdata : r_call_target;
      end
    end
  end

  assign sp_wdata  = r_sp_wdata;
  assign sp_write  = r_sp_write;
  assign reg_wdata = r_reg_wdata;
  assign reg_write = r_reg_write;
  assign pc_target = r_pc_target;
  assign pc_load   = r_pc_load;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_stack_engine.sv
module tb_stack_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] push_data, ret_addr, call_target, sp_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [31:0] sp_wdata, reg_wdata, pc_target;
  logic        sp_write, reg_write, pc_load, busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stack_engine dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .push_data(push_data), .ret_addr(ret_addr), .call_target(call_target),
    .sp_in(sp_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .sp_wdata(sp_wdata), .sp_write(sp_write),
    .reg_wdata(reg_wdata), .reg_write(reg_write),
    .pc_target(pc_target), .pc_load(pc_load),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] push_data;
    logic [31:0] ret_addr;
    logic [31:0] call_target;
    logic [31:0] sp_in;
    logic [31:0] rdata;
    int          ack_delay;
    logic        exp_err;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_sp;
    logic        exp_reg_write;
    logic [31:0] exp_reg;
    logic        exp_pc_load;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_start(input logic [1:0] o, input logic [31:0] pd,
                             input logic [31:0] ra, input logic [31:0] ct,
                             input logic [31:0] sp);
    @(negedge clk);
    op = o; push_data = pd; ret_addr = ra; call_target = ct; sp_in = sp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    drive_start(v.op, v.push_data, v.ret_addr, v.call_target, v.sp_in);
    if (v.exp_err) begin
      check("err_done", {31'd0, done}, 32'd1);
      check("err_err", {31'd0, err}, 32'd1);
      check("err_no_req", {31'd0, mem_req}, 32'd0);
      check("err_no_spw", {31'd0, sp_write}, 32'd0);
      check("err_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("err_idle_busy", {31'd0, busy}, 32'd0);
      check("err_done_fall", {31'd0, done}, 32'd0);
      check("err_no_req2", {31'd0, mem_req}, 32'd0);
    end else begin
      check("mem_req", {31'd0, mem_req}, 32'd1);
      check("mem_we", {31'd0, mem_we}, {31'd0, v.exp_we});
      check("mem_addr", mem_addr, v.exp_addr);
      if (v.exp_we) check("mem_wdata", mem_wdata, v.exp_wdata);
      check("mem_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < v.ack_delay; i++) begin
        @(negedge clk);
        check("wait_req", {31'd0, mem_req}, 32'd1);
        check("wait_addr", mem_addr, v.exp_addr);
        check("wait_done", {31'd0, done}, 32'd0);
      end
      mem_ack = 1'b1; mem_rdata = v.rdata;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'd0;
      check("cm_done", {31'd0, done}, 32'd1);
      check("cm_err", {31'd0, err}, 32'd0);
      check("cm_req", {31'd0, mem_req}, 32'd0);
      check("cm_spw", {31'd0, sp_write}, 32'd1);
      check("cm_sp", sp_wdata, v.exp_sp);
      check("cm_regw", {31'd0, reg_write}, {31'd0, v.exp_reg_write});
      if (v.exp_reg_write) check("cm_reg", reg_wdata, v.exp_reg);
      check("cm_pcl", {31'd0, pc_load}, {31'd0, v.exp_pc_load});
      if (v.exp_pc_load) check("cm_pc", pc_target, v.exp_pc);
      @(negedge clk);
      check("post_busy", {31'd0, busy}, 32'd0);
      check("post_done", {31'd0, done}, 32'd0);
      check("post_spw", {31'd0, sp_write}, 32'd0);
    end
    $display("vec %0d: op=%0d sp_in=%0d err_expected=%0d", idx, v.op, v.sp_in, v.exp_err);
  endtask

  function automatic vec_t mk(input logic [1:0] o, input logic [31:0] pd,
                              input logic [31:0] ra, input logic [31:0] ct,
                              input logic [31:0] sp, input logic [31:0] rd,
                              input int dly, input logic e, input logic we,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] nsp, input logic rw,
                              input logic [31:0] rv, input logic pl,
                              input logic [31:0] pc);
    vec_t v;
    v.op = o; v.push_data = pd; v.ret_addr = ra; v.call_target = ct;
    v.sp_in = sp; v.rdata = rd; v.ack_delay = dly; v.exp_err = e;
    v.exp_we = we; v.exp_addr = addr; v.exp_wdata = wd; v.exp_sp = nsp;
    v.exp_reg_write = rw; v.exp_reg = rv; v.exp_pc_load = pl; v.exp_pc = pc;
    return v;
  endfunction

  initial begin
    //           op     push_data     ret_addr  call_tgt  sp  rdata    dly err we addr wdata         nsp rw reg      pl pc
    vecs[0] = mk(2'b00, 32'hDEADBEEF, 32'h0,    32'h0,    16, 32'h0,    3, 0, 1, 15, 32'hDEADBEEF, 15, 0, 32'h0,    0, 32'h0);
    vecs[1] = mk(2'b01, 32'h0,        32'h0,    32'h0,    15, 32'h1234, 0, 0, 0, 15, 32'h0,        16, 1, 32'h1234, 0, 32'h0);
    vecs[2] = mk(2'b10, 32'h0,        32'h40,   32'h100,  10, 32'h0,    0, 0, 1, 9,  32'h40,       9,  0, 32'h0,    1, 32'h100);
    vecs[3] = mk(2'b11, 32'h0,        32'h0,    32'h0,    9,  32'h40,   1, 0, 0, 9,  32'h0,        10, 0, 32'h0,    1, 32'h40);
    vecs[4] = mk(2'b00, 32'h1111,     32'h0,    32'h0,    0,  32'h0,    0, 1, 0, 0,  32'h0,        0,  0, 32'h0,    0, 32'h0);
    vecs[5] = mk(2'b01, 32'h0,        32'h0,    32'h0,    16, 32'h0,    0, 1, 0, 0,  32'h0,        0,  0, 32'h0,    0, 32'h0);
    vecs[6] = mk(2'b10, 32'h0,        32'h5,    32'h6,    0,  32'h0,    0, 1, 0, 0,  32'h0,        0,  0, 32'h0,    0, 32'h0);
    vecs[7] = mk(2'b11, 32'h0,        32'h0,    32'h0,    16, 32'h0,    0, 1, 0, 0,  32'h0,        0,  0, 32'h0,    0, 32'h0);
    vecs[8] = mk(2'b00, 32'hA5A5A5A5, 32'h0,    32'h0,    1,  32'h0,    1, 0, 1, 0,  32'hA5A5A5A5, 0,  0, 32'h0,    0, 32'h0);
    vecs[9] = mk(2'b01, 32'h0,        32'h0,    32'h0,    0,  32'h77,   2, 0, 0, 0,  32'h0,        1,  1, 32'h77,   0, 32'h0);

    rst = 1'b1; start = 1'b0; op = 2'b00; push_data = 32'd0; ret_addr = 32'd0;
    call_target = 32'd0; sp_in = 32'd16; mem_rdata = 32'd0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_sp", sp_wdata, 32'd0);
    check("rst_spw", {31'd0, sp_write}, 32'd0);
    check("rst_reg", reg_wdata, 32'd0);
    check("rst_regw", {31'd0, reg_write}, 32'd0);
    check("rst_pc", pc_target, 32'd0);
    check("rst_pcl", {31'd0, pc_load}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // mem_ack while idle must not start anything
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("idle_ack_busy", {31'd0, busy}, 32'd0);
    check("idle_ack_spw", {31'd0, sp_write}, 32'd0);
    $display("seq idle_ack: done");

    // start pulsed during MEM is ignored; the original PUSH completes unchanged
    drive_start(2'b00, 32'h0BADF00D, 32'h0, 32'h0, 32'd16);
    check("ign_req", {31'd0, mem_req}, 32'd1);
    op = 2'b01; sp_in = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_addr", mem_addr, 32'd15);
    check("ign_we", {31'd0, mem_we}, 32'd1);
    check("ign_wdata", mem_wdata, 32'h0BADF00D);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_sp", sp_wdata, 32'd15);
    check("ign_regw", {31'd0, reg_write}, 32'd0);
    @(negedge clk);
    check("ign_idle", {31'd0, busy}, 32'd0);
    check("ign_no_req", {31'd0, mem_req}, 32'd0);
    $display("seq start_in_mem: done");

    // reset during MEM abandons the access with no strobes
    drive_start(2'b00, 32'h12345678, 32'h0, 32'h0, 32'd16);
    check("rm_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rm_req_low", {31'd0, mem_req}, 32'd0);
    check("rm_busy", {31'd0, busy}, 32'd0);
    check("rm_done", {31'd0, done}, 32'd0);
    check("rm_spw", {31'd0, sp_write}, 32'd0);
    @(negedge clk);
    check("rm_done2", {31'd0, done}, 32'd0);
    check("rm_spw2", {31'd0, sp_write}, 32'd0);
    $display("seq reset_in_mem: done");
    run_vec(10, mk(2'b00, 32'hCAFEF00D, 32'h0, 32'h0, 16, 32'h0, 0, 0, 1, 15,
                   32'hCAFEF00D, 15, 0, 32'h0, 0, 32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
